nios_ctrl_sequencer: RTL

- Consumes the 32-bit control word driven by the NIOS control PIO (`out_port`). Turns it into three kinds of output:
  - registered level outputs
  - fixed-width strobes on rising edges of selected bits
  - an ordered, timed 4-stage enable ramp (RF enable chain) with reverse-order shutdown
- Its status word feeds back into the PIO `in_port`.

---
 rtl/nios_ctrl_sequencer_if.sv | 28 ++
 rtl/nios_ctrl_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/nios_ctrl_sequencer_if.sv
// Control/status bundle between the NIOS PIO and the control sequencer.
// Master is the PIO side, slave is the sequencer.
interface nios_ctrl_sequencer_if;
    logic [31:0] ctrl_word;
    logic [31:0] level_out;
    logic [31:0] pulse_out;
    logic [3:0]  en_seq;
    logic        busy;
    logic [31:0] status_word;

    modport master (
        output ctrl_word,
        input  level_out,
        input  pulse_out,
        input  en_seq,
        input  busy,
        input  status_word
    );

    modport slave (
        input  ctrl_word,
        output level_out,
        output pulse_out,
        output en_seq,
        output busy,
        output status_word
    );
endinterface

// File: rtl/nios_ctrl_sequencer.sv
// NIOS control-word sequencer: levels, stretched strobes, RF enable ramp.
// Define NIOS_CTRL_SEQ_STATUS_EN to drive status_word; otherwise it is tied to 0.
module nios_ctrl_sequencer #(
    parameter logic [31:0] PULSE_MASK = 32'h0000_00F0,
    parameter int          PULSE_LEN  = 16,
    parameter int          SEQ_BIT    = 0,
    parameter int          SEQ_DELAY  = 100
) (
    input  logic clk,
    input  logic reset,
    nios_ctrl_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    localparam logic [31:0] LVL_MASK = ~PULSE_MASK & ~(32'd1 << SEQ_BIT);
    localparam logic [15:0] RELOAD   = 16'(SEQ_DELAY - 1);
    localparam logic [7:0]  LEN8     = 8'(PULSE_LEN);

    logic [31:0] ctrl_q;
    logic [31:0] ctrl_d;
    logic [31:0] rise;
    logic [31:0] level_q;
    logic [7:0]  cnt [32];
    logic [31:0] pulse;
    state_t      state;
    logic [3:0]  en_q;
    logic [15:0] tmr;
    logic        busy_q;
    logic        req;

    assign rise = ctrl_q & ~ctrl_d;
    assign req  = ctrl_q[SEQ_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            ctrl_d  <= '0;
            level_q <= '0;
        end else begin
            ctrl_q  <= bus.ctrl_word;
            ctrl_d  <= ctrl_q;
            level_q <= ctrl_q & LVL_MASK;
        end
    end

    // Counters outside the mask stay at zero and fold away.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (reset || !PULSE_MASK[i])
                cnt[i] <= '0;
            else if (rise[i])
                cnt[i] <= LEN8;
            else if (cnt[i] != 8'd0)
                cnt[i] <= cnt[i] - 8'd1;
        end
    end

    always_comb begin
        pulse = '0;
        for (int i = 0; i < 32; i++)
            pulse[i] = (cnt[i] != 8'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_OFF;
            en_q   <= '0;
            tmr    <= '0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                S_OFF: begin
                    if (req) begin
                        en_q   <= 4'b0001;
                        tmr    <= RELOAD;
                        state  <= S_UP;
                        busy_q <= 1'b1;
                    end
                end
                S_UP: begin
                    if (!req) begin
                        tmr   <= RELOAD;
                        state <= S_DOWN;
                    end else if (tmr == 16'd0) begin
                        en_q <= {en_q[2:0], 1'b1};
                        tmr  <= RELOAD;
                        if (en_q[2]) begin
                            state  <= S_ON;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                S_ON: begin
                    if (!req) begin
                        en_q   <= 4'b0111;
                        tmr    <= RELOAD;
                        state  <= S_DOWN;
                        busy_q <= 1'b1;
                    end
                end
                S_DOWN: begin
                    if (req) begin
                        tmr   <= RELOAD;
                        state <= S_UP;
                    end else if (tmr == 16'd0) begin
                        en_q <= {1'b0, en_q[3:1]};
                        tmr  <= RELOAD;
                        if (!en_q[1]) begin
                            state  <= S_OFF;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                default: state <= S_OFF;
            endcase
        end
    end

`ifdef NIOS_CTRL_SEQ_STATUS_EN
    logic [31:0] cnt_gt1;
    logic        pulse_any_q;

    always_comb begin
        cnt_gt1 = '0;
        for (int i = 0; i < 32; i++)
            cnt_gt1[i] = (cnt[i] > 8'd1);
    end

    // Tracks |pulse_out on the same edge the counters update.
    always_ff @(posedge clk) begin
        if (reset)
            pulse_any_q <= 1'b0;
        else
            pulse_any_q <= |(PULSE_MASK & (rise | cnt_gt1));
    end

    assign bus.status_word = {state, 25'd0, pulse_any_q, en_q};
`else
    assign bus.status_word = '0;
`endif

    assign bus.level_out = level_q;
    assign bus.pulse_out = pulse;
    assign bus.en_seq    = en_q;
    assign bus.busy      = busy_q;

endmodule
